// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - seven-segment scan monitor decoding multiplexed digits into committed frames
// Optional SEG_CAPTURE_HEX_EN adds A-F glyph decoding.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  an,
  input  logic [6:0]  a_to_g,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  seg_err,
  output logic        frame_stb,
  output logic        frame_valid,
  output logic        stale,
  output logic        an_err
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    SETTLE_M1 = 8'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [10:0]   IDLE_IN   = 11'h7FF;

  // Returns {err, blank, value}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h40:   r = 6'h00;
      7'h79:   r = 6'h01;
      7'h24:   r = 6'h02;
      7'h30:   r = 6'h03;
      7'h19:   r = 6'h04;
      7'h12:   r = 6'h05;
      7'h02:   r = 6'h06;
      7'h78:   r = 6'h07;
      7'h00:   r = 6'h08;
      7'h10:   r = 6'h09;
      7'h7F:   r = 6'b01_1111;
`ifdef SEG_CAPTURE_HEX_EN
      7'h08:   r = 6'h0A;
      7'h03:   r = 6'h0B;
      7'h46:   r = 6'h0C;
      7'h21:   r = 6'h0D;
      7'h06:   r = 6'h0E;
      7'h0E:   r = 6'h0F;
`endif
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] a);
    return 3'(!a[0]) + 3'(!a[1]) + 3'(!a[2]) + 3'(!a[3]);
  endfunction

  logic [10:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   sh_dig_q, sh_dig_d;
  logic [3:0]    sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
  logic [15:0]   dig_q, dig_d;
  logic [3:0]    blank_q, blank_d, err_q, err_d;
  logic          stb_q, stb_d, valid_q, valid_d, stale_q, stale_d, an_err_q, an_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          changed, multi, multi_prev, one_hot, sample, commit;
  logic [1:0]    idx;
  logic [5:0]    dec;
  logic [3:0]    seen_w;

  always_comb begin
    sync1_d    = {an, a_to_g};
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    changed    = (sync2_q != prev_q);
    multi      = (low_count(sync2_q[10:7]) >= 3'd2);
    multi_prev = (low_count(prev_q[10:7]) >= 3'd2);
    one_hot    = (low_count(sync2_q[10:7]) == 3'd1);

    idx = 2'd0;
    case (sync2_q[10:7])
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    dec = decode(sync2_q[6:0]);

    // A held multi-select keeps the dwell count pinned so it can never sample.
    if (multi || changed) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    sample   = one_hot && !changed && (cnt_q == SETTLE_M1);
    an_err_d = multi && !multi_prev;

    sh_dig_d   = sh_dig_q;
    sh_blank_d = sh_blank_q;
    sh_err_d   = sh_err_q;
    seen_w     = seen_q;
    if (sample) begin
      sh_dig_d[{idx, 2'b00} +: 4] = dec[3:0];
      sh_blank_d[idx]             = dec[4];
      sh_err_d[idx]               = dec[5];
      seen_w[idx]                 = 1'b1;
    end
    commit = sample && (seen_w == 4'hF);

    dig_d   = dig_q;
    blank_d = blank_q;
    err_d   = err_q;
    stb_d   = 1'b0;
    valid_d = valid_q;
    stale_d = stale_q;
    seen_d  = seen_w;
    tmo_d   = tmo_q;
    if (commit) begin
      dig_d   = sh_dig_d;
      blank_d = sh_blank_d;
      err_d   = sh_err_d;
      stb_d   = 1'b1;
      valid_d = 1'b1;
      stale_d = 1'b0;
      seen_d  = 4'h0;
      tmo_d   = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
      // Only the crossing clears seen; once saturated, scanning can rebuild a frame.
      if (tmo_d == TMO_MAX) begin
        stale_d = 1'b1;
        valid_d = 1'b0;
        seen_d  = 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q    <= IDLE_IN;
      sync2_q    <= IDLE_IN;
      prev_q     <= IDLE_IN;
      cnt_q      <= 8'd0;
      seen_q     <= 4'h0;
      sh_dig_q   <= 16'h0000;
      sh_blank_q <= 4'h0;
      sh_err_q   <= 4'h0;
      dig_q      <= 16'h0000;
      blank_q    <= 4'h0;
      err_q      <= 4'h0;
      stb_q      <= 1'b0;
      valid_q    <= 1'b0;
      stale_q    <= 1'b0;
      an_err_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      sh_dig_q   <= sh_dig_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q   <= sh_err_d;
      dig_q      <= dig_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      stb_q      <= stb_d;
      valid_q    <= valid_d;
      stale_q    <= stale_d;
      an_err_q   <= an_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign digits      = dig_q;
  assign blank       = blank_q;
  assign seg_err     = err_q;
  assign frame_stb   = stb_q;
  assign frame_valid = valid_q;
  assign stale       = stale_q;
  assign an_err      = an_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - scoreboard bench for seg_scan_capture with a dwell-level reference model
module tb_seg_scan_capture;

  localparam int S   = 4;
  localparam int TMO = 512;

  localparam logic [6:0] STD_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] HEX_PAT [6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [3:0] MULTI_AN [8] = '{4'b0011, 4'b0101, 4'b0000, 4'b1001,
                                          4'b0110, 4'b1100, 4'b1010, 4'b0001};

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  an_i = 4'hF;
  logic [6:0]  seg_i = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  blank, seg_err;
  logic        frame_stb, frame_valid, stale, an_err;

  seg_scan_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .an(an_i), .a_to_g(seg_i),
    .digits(digits), .blank(blank), .seg_err(seg_err),
    .frame_stb(frame_stb), .frame_valid(frame_valid), .stale(stale), .an_err(an_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: works on runs of identical input values (dwells).
  logic [23:0] exp_q[$];
  logic [10:0] run_val = 11'h7FF;
  int          run_len = 1000;
  logic [3:0]  m_seen = 4'h0;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_blank = 4'h0, m_err = 4'h0;
  logic [15:0] m_last_dig = 16'h0;
  int          exp_an_err = 0;

  function automatic int lows(input logic [3:0] a);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) c++;
    return c;
  endfunction

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == STD_PAT[i]) return {2'b00, 4'(i)};
    if (p == 7'h7F) return 6'b01_1111;
`ifdef SEG_CAPTURE_HEX_EN
    for (int i = 0; i < 6; i++) if (p == HEX_PAT[i]) return {2'b00, 4'(10 + i)};
`endif
    return 6'b10_0000;
  endfunction

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    logic [5:0] d;
    int k;
    if ({a, s} == run_val) begin
      run_len++;
    end else begin
      if (lows(a) >= 2 && lows(run_val[10:7]) < 2) exp_an_err++;
      run_val = {a, s};
      run_len = 1;
    end
    if (run_len == S + 1 && lows(a) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) k = i;
      d = ref_decode(s);
      m_dig[k]   = d[3:0];
      m_blank[k] = d[4];
      m_err[k]   = d[5];
      m_seen[k]  = 1'b1;
      if (m_seen == 4'hF) begin
        m_last_dig = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        exp_q.push_back({m_last_dig, m_blank, m_err});
        m_seen = 4'h0;
      end
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    for (int i = 0; i < len; i++) begin
      an_i  = a;
      seg_i = s;
      model_step(a, s);
      @(posedge clk);
      #1;
    end
  endtask

  // pats holds d3..d0 (7 bits each); order lists the digit index for each dwell in bits [1:0] first.
  task automatic scan_frame(input logic [27:0] pats, input logic [7:0] order, input int len);
    logic [1:0] ix;
    dwell(4'hF, 7'h7F, 2);
    for (int k = 0; k < 4; k++) begin
      ix = order[2*k +: 2];
      dwell(~(4'b0001 << ix), pats[7*ix +: 7], len);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a frame.
  int          stb_count = 0;
  int          got_an_err = 0;
  logic [23:0] e;

  always @(negedge clk) begin
    if (!clr) begin
      if (an_err) got_an_err++;
      if (frame_stb) begin
        stb_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame actual digits=%h expected no frame", digits);
        end else begin
          e = exp_q.pop_front();
          chk("frame_digits", 32'(digits), 32'(e[23:8]));
          chk("frame_blank", 32'(blank), 32'(e[7:4]));
          chk("frame_seg_err", 32'(seg_err), 32'(e[3:0]));
          chk("frame_valid_on_stb", 32'(frame_valid), 32'd1);
          chk("stale_on_stb", 32'(stale), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  int base;
  logic [3:0] ra;
  logic [6:0] rs;
  int r;

  initial begin
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_seg_err", 32'(seg_err), 32'h0);
    chk("rst_frame_stb", 32'(frame_stb), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    chk("rst_an_err", 32'(an_err), 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    dwell(4'hF, 7'h7F, 4);

    // 9,5,9,5 in scan order, then out of order.
    scan_frame({7'h12, 7'h10, 7'h12, 7'h10}, 8'b11_10_01_00, 16);
    chk("t1_digits", 32'(digits), 32'h5959);
    chk("t1_frame_valid", 32'(frame_valid), 32'd1);
    base = stb_count;
    scan_frame({7'h12, 7'h10, 7'h12, 7'h10}, 8'b01_11_00_10, 16);
    chk("t2_digits", 32'(digits), 32'h5959);
    chk("t2_one_commit", 32'(stb_count - base), 32'd1);

    // Dwells of SETTLE_CYCLES are too short to sample.
    base = stb_count;
    scan_frame({7'h19, 7'h30, 7'h24, 7'h79}, 8'b11_10_01_00, S);
    dwell(4'hF, 7'h7F, 10);
    chk("t3_short_no_commit", 32'(stb_count - base), 32'd0);

    scan_frame({7'h7F, 7'h7F, 7'h02, 7'h40}, 8'b11_10_01_00, 16);
    chk("t4_digits", 32'(digits), 32'hFF60);
    chk("t4_blank", 32'(blank), 32'b1100);

    scan_frame({7'h30, 7'h24, 7'h79, 7'h08}, 8'b11_10_01_00, 16);
`ifdef SEG_CAPTURE_HEX_EN
    chk("t5_digits", 32'(digits), 32'h321A);
    chk("t5_seg_err", 32'(seg_err), 32'b0000);
`else
    chk("t5_digits", 32'(digits), 32'h3210);
    chk("t5_seg_err", 32'(seg_err), 32'b0001);
`endif

    base = got_an_err;
    dwell(4'b0011, 7'h40, 20);
    dwell(4'hF, 7'h7F, 4);
    chk("t6_an_err_pulses", 32'(got_an_err - base), 32'd1);

    // Silence until timeout: stale, not valid, digits retained.
    dwell(4'hF, 7'h7F, TMO + 20);
    m_seen = 4'h0;
    chk("t7_stale", 32'(stale), 32'd1);
    chk("t7_frame_valid", 32'(frame_valid), 32'd0);
    chk("t7_digits_kept", 32'(digits), 32'(m_last_dig));

    // Two digits, then clear; post-clear scan starts with the other two digits.
    dwell(4'b1110, 7'h78, 16);
    dwell(4'b1101, 7'h78, 16);
    dwell(4'hF, 7'h7F, 6);
    clr = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    m_seen = 4'h0;
    m_blank = 4'h0;
    m_err = 4'h0;
    m_last_dig = 16'h0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    chk("t8_valid_after_clr", 32'(frame_valid), 32'd0);
    chk("t8_digits_after_clr", 32'(digits), 32'h0);
    base = stb_count;
    scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 8'b01_00_11_10, 16);
    chk("t8_one_commit", 32'(stb_count - base), 32'd1);
    chk("t8_digits", 32'(digits), 32'h1234);

    // Randomized dwells against the model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) ra = 4'hF;
      else if (r == 1) ra = MULTI_AN[$urandom_range(0, 7)];
      else ra = ~(4'b0001 << $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r <= 5) rs = STD_PAT[$urandom_range(0, 9)];
      else if (r == 6) rs = 7'h7F;
      else if (r == 7) rs = HEX_PAT[$urandom_range(0, 5)];
      else rs = 7'($urandom);
      dwell(ra, rs, $urandom_range(2, 12));
    end
    dwell(4'hF, 7'h7F, 20);

    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("end_an_err_total", 32'(got_an_err), 32'(exp_an_err));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
